// File: rtl/matmul_agen.sv
// Loop-nest address generator for the matmul datapath: one (A,B,C) address beat per MAC step.
// Optional transposed-B addressing is compiled in with MATMUL_AGEN_BT_EN.
module matmul_agen #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dimM,
  input  logic [WIDTH-1:0] dimK,
  input  logic [WIDTH-1:0] dimN,
  input  logic [WIDTH-1:0] baseA,
  input  logic [WIDTH-1:0] baseB,
  input  logic [WIDTH-1:0] baseC,
`ifdef MATMUL_AGEN_BT_EN
  input  logic             b_trans,
`endif
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] addrA,
  output logic [WIDTH-1:0] addrB,
  output logic [WIDTH-1:0] addrC,
  output logic             first,
  output logic             last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q;
  logic             busy_q, done_q, valid_q, first_q, last_q;
  logic [WIDTH-1:0] m_q, k_q, n_q, baseb_q;
  logic [WIDTH-1:0] i_q, j_q, kk_q;
  logic [WIDTH-1:0] rowa_q, colb_q;
  logic [WIDTH-1:0] addra_q, addrb_q, addrc_q;
`ifdef MATMUL_AGEN_BT_EN
  logic             bt_q;
`endif

  logic             kk_last, j_last, i_last, final_beat, last_d;
  logic [WIDTH-1:0] step_k, step_col;
  logic [WIDTH-1:0] i_d, j_d, kk_d, rowa_d, colb_d, pa_d, pb_d, pc_d;

  // pB steps by one row (N) per k when row-major; by one element when transposed.
  always_comb begin
`ifdef MATMUL_AGEN_BT_EN
    step_k   = bt_q ? ONE : n_q;
    step_col = bt_q ? k_q : ONE;
`else
    step_k   = n_q;
    step_col = ONE;
`endif
  end

  always_comb begin
    kk_last    = (kk_q == k_q - ONE);
    j_last     = (j_q == n_q - ONE);
    i_last     = (i_q == m_q - ONE);
    final_beat = kk_last && j_last && i_last;
    kk_d   = kk_q + ONE;
    j_d    = j_q;
    i_d    = i_q;
    rowa_d = rowa_q;
    colb_d = colb_q;
    pa_d   = addra_q + ONE;
    pb_d   = addrb_q + step_k;
    pc_d   = addrc_q;
    if (kk_last) begin
      kk_d = ZERO;
      pc_d = addrc_q + ONE;
      if (!j_last) begin
        j_d    = j_q + ONE;
        colb_d = colb_q + step_col;
        pa_d   = rowa_q;
        pb_d   = colb_q + step_col;
      end else begin
        j_d    = ZERO;
        i_d    = i_q + ONE;
        rowa_d = rowa_q + k_q;
        pa_d   = rowa_q + k_q;
        colb_d = baseb_q;
        pb_d   = baseb_q;
      end
    end
    last_d = (kk_d == k_q - ONE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      addra_q <= ZERO;
      addrb_q <= ZERO;
      addrc_q <= ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= dimM;
            k_q     <= dimK;
            n_q     <= dimN;
            baseb_q <= baseB;
`ifdef MATMUL_AGEN_BT_EN
            bt_q    <= b_trans;
`endif
            i_q     <= ZERO;
            j_q     <= ZERO;
            kk_q    <= ZERO;
            rowa_q  <= baseA;
            colb_q  <= baseB;
            addra_q <= baseA;
            addrb_q <= baseB;
            addrc_q <= baseC;
            if (dimM == ZERO || dimK == ZERO || dimN == ZERO) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              first_q <= 1'b1;
              last_q  <= (dimK == ONE);
            end
          end
        end
        RUN: begin
          if (valid_q && out_ready) begin
            if (final_beat) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              first_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              kk_q    <= kk_d;
              j_q     <= j_d;
              i_q     <= i_d;
              rowa_q  <= rowa_d;
              colb_q  <= colb_d;
              addra_q <= pa_d;
              addrb_q <= pb_d;
              addrc_q <= pc_d;
              first_q <= (kk_d == ZERO);
              last_q  <= last_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign first     = first_q;
  assign last      = last_q;
  assign addrA     = addra_q;
  assign addrB     = addrb_q;
  assign addrC     = addrc_q;

endmodule
